// File: rtl/neur_in_pkg.sv
// ============================================================================
// neur_in_pkg : shared types, constants and helpers for neur_in_unpack_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package neur_in_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 16;

   typedef enum logic [1:0] {
      PREC_8 = 2'b00,
      PREC_4 = 2'b01,
      PREC_2 = 2'b10
   } prec_e;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_BUSY  = 1'b1
   } state_e;

   function automatic logic [2:0] nbeats(input prec_e p);
      case (p)
         PREC_4:  nbeats = 3'd2;
         PREC_2:  nbeats = 3'd4;
         default: nbeats = 3'd1;
      endcase
   endfunction

   function automatic logic [4:0] elem_width(input prec_e p);
      case (p)
         PREC_4:  elem_width = 5'd4;
         PREC_2:  elem_width = 5'd2;
         default: elem_width = 5'd8;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/neur_in_lane_ext.sv
// ============================================================================
// neur_in_lane_ext : extracts one packed element and extends it to a lane.
// Optional zero-point subtraction under NEUR_IN_ZP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module neur_in_lane_ext
   import neur_in_pkg::*;
#(
   parameter int LANE_IDX = 0,
   parameter int LANE_W   = neur_in_pkg::LANE_W
) (
   input  logic [31:0]       word_i,
   input  prec_e             prec_i,
   input  logic [1:0]        beat_i,
   input  logic              signed_i,
`ifdef NEUR_IN_ZP_EN
   input  logic [7:0]        zp_i,
`endif
   output logic [LANE_W-1:0] lane_o
);

   logic [3:0]        elem_idx;
   logic [8:0]        shamt;
   logic [31:0]       shifted;
   logic [LANE_W-1:0] ext;

   assign elem_idx = {beat_i, 2'(LANE_IDX)};
   assign shamt    = 9'(elem_width(prec_i)) * 9'(elem_idx);
   // Element e lands in the MSBs after shifting left by W*e.
   assign shifted  = word_i << shamt;

   always_comb begin
      ext = '0;
      case (prec_i)
         PREC_4:  ext = {{(LANE_W-4){signed_i & shifted[31]}}, shifted[31:28]};
         PREC_2:  ext = {{(LANE_W-2){signed_i & shifted[31]}}, shifted[31:30]};
         default: ext = {{(LANE_W-8){signed_i & shifted[31]}}, shifted[31:24]};
      endcase
   end

`ifdef NEUR_IN_ZP_EN
   assign lane_o = ext - {{(LANE_W-8){1'b0}}, zp_i};
`else
   assign lane_o = ext;
`endif

endmodule

`default_nettype wire

// File: rtl/neur_in_unpack_unit.sv
// ============================================================================
// neur_in_unpack_unit : unpacks 8b/4b/2b packed words into 4 extended lanes
// per beat. Optional zero-point input under NEUR_IN_ZP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module neur_in_unpack_unit
   import neur_in_pkg::*;
#(
   parameter int LANES  = neur_in_pkg::LANES,
   parameter int LANE_W = neur_in_pkg::LANE_W
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [31:0]             in_word_i,
   input  logic [1:0]              prec_i,
   input  logic                    signed_i,
`ifdef NEUR_IN_ZP_EN
   input  logic [7:0]              zp_i,
`endif
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [LANES*LANE_W-1:0] out_vals_o,
   output logic                    out_last_o
);

   state_e      state_q, state_d;
   logic [1:0]  beat_q,  beat_d;
   logic [31:0] word_q,  word_d;
   prec_e       prec_q,  prec_d;
   logic        sgn_q,   sgn_d;
`ifdef NEUR_IN_ZP_EN
   logic [7:0]  zp_q,    zp_d;
`endif

   logic       busy;
   logic       last;
   logic       accept;
   logic       xfer;
   logic [2:0] nb;
   logic [LANES*LANE_W-1:0] lanes;

   assign busy   = (state_q == ST_BUSY);
   assign nb     = nbeats(prec_q);
   assign last   = ({1'b0, beat_q} == (nb - 3'd1));
   assign in_ready_o  = !flush_i & (!busy | (out_ready_i & last));
   assign accept      = in_valid_i & in_ready_o;
   assign xfer        = busy & out_ready_i;
   assign out_valid_o = busy;
   assign out_last_o  = busy & last;
   assign out_vals_o  = busy ? lanes : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         beat_q  <= 2'd0;
         word_q  <= 32'd0;
         prec_q  <= PREC_8;
         sgn_q   <= 1'b0;
`ifdef NEUR_IN_ZP_EN
         zp_q    <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         word_q  <= word_d;
         prec_q  <= prec_d;
         sgn_q   <= sgn_d;
`ifdef NEUR_IN_ZP_EN
         zp_q    <= zp_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      word_d  = word_q;
      prec_d  = prec_q;
      sgn_d   = sgn_q;
`ifdef NEUR_IN_ZP_EN
      zp_d    = zp_q;
`endif
      if (flush_i) begin
         state_d = ST_EMPTY;
         beat_d  = 2'd0;
         word_d  = 32'd0;
      end else begin
         if (xfer) begin
            if (last) begin
               state_d = ST_EMPTY;
               beat_d  = 2'd0;
            end else begin
               beat_d  = beat_q + 2'd1;
            end
         end
         // An accept on the last beat overrides the drain so words run back-to-back.
         if (accept) begin
            state_d = ST_BUSY;
            beat_d  = 2'd0;
            word_d  = in_word_i;
            prec_d  = (prec_i == 2'b11) ? PREC_8 : prec_e'(prec_i);
            sgn_d   = signed_i;
`ifdef NEUR_IN_ZP_EN
            zp_d    = zp_i;
`endif
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      neur_in_lane_ext #(
         .LANE_IDX (k),
         .LANE_W   (LANE_W)
      ) u_lane (
         .word_i   (word_q),
         .prec_i   (prec_q),
         .beat_i   (beat_q),
         .signed_i (sgn_q),
`ifdef NEUR_IN_ZP_EN
         .zp_i     (zp_q),
`endif
         .lane_o   (lanes[(LANES-1-k)*LANE_W +: LANE_W])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_neur_in_unpack_unit.sv
// ============================================================================
// tb_neur_in_unpack_unit : table-driven directed bench for neur_in_unpack_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neur_in_unpack_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic [1:0]  prec;
   logic        sgn;
`ifdef NEUR_IN_ZP_EN
   logic [7:0]  zp;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_vals;
   logic        out_last;

   int total = 0;
   int bad   = 0;

   neur_in_unpack_unit dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_word_i   (in_word),
      .prec_i      (prec),
      .signed_i    (sgn),
`ifdef NEUR_IN_ZP_EN
      .zp_i        (zp),
`endif
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_vals_o  (out_vals),
      .out_last_o  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]      word;
      logic [1:0]       prec;
      logic             sgn;
      logic [2:0]       nb;
      logic [3:0][63:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{32'h80FF017F, 2'b00, 1'b1, 3'd1,
                  {64'h0, 64'h0, 64'h0, 64'hFF80_FFFF_0001_007F}};
      vecs[1] = '{32'h80FF017F, 2'b00, 1'b0, 3'd1,
                  {64'h0, 64'h0, 64'h0, 64'h0080_00FF_0001_007F}};
      vecs[2] = '{32'h89ABCDEF, 2'b01, 1'b1, 3'd2,
                  {64'h0, 64'h0, 64'hFFFC_FFFD_FFFE_FFFF, 64'hFFF8_FFF9_FFFA_FFFB}};
      vecs[3] = '{32'h89ABCDEF, 2'b01, 1'b0, 3'd2,
                  {64'h0, 64'h0, 64'h000C_000D_000E_000F, 64'h0008_0009_000A_000B}};
      vecs[4] = '{32'h1B1B1B1B, 2'b10, 1'b1, 3'd4,
                  {4{64'h0000_0001_FFFE_FFFF}}};
      vecs[5] = '{32'h1B1B1B1B, 2'b10, 1'b0, 3'd4,
                  {4{64'h0000_0001_0002_0003}}};
      // Reserved precision code behaves as 8b.
      vecs[6] = '{32'h80FF017F, 2'b11, 1'b1, 3'd1,
                  {64'h0, 64'h0, 64'h0, 64'hFF80_FFFF_0001_007F}};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0;
      prec = 2'b00; sgn = 1'b0; out_ready = 1'b1;
`ifdef NEUR_IN_ZP_EN
      zp = 8'd0;
`endif
      #12;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
      chk("reset_out_vals",  out_vals,           64'd0);
      chk("reset_out_last",  {63'd0, out_last},  64'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 7; v++) begin
         in_valid = 1'b1; in_word = vecs[v].word;
         prec = vecs[v].prec; sgn = vecs[v].sgn;
         chk($sformatf("v%0d_accept_ready", v), {63'd0, in_ready}, 64'd1);
         tick();
         in_valid = 1'b0;
         prec = ~vecs[v].prec; sgn = ~vecs[v].sgn;  // must not disturb word in flight
         for (int b = 0; b < int'(vecs[v].nb); b++) begin
            chk($sformatf("v%0d_b%0d_valid", v, b), {63'd0, out_valid}, 64'd1);
            chk($sformatf("v%0d_b%0d_vals", v, b), out_vals, vecs[v].exp[b]);
            chk($sformatf("v%0d_b%0d_last", v, b), {63'd0, out_last},
                {63'd0, (b == int'(vecs[v].nb) - 1)});
            chk($sformatf("v%0d_b%0d_in_ready", v, b), {63'd0, in_ready},
                {63'd0, (b == int'(vecs[v].nb) - 1)});
            tick();
         end
         chk($sformatf("v%0d_idle", v), {63'd0, out_valid}, 64'd0);
      end

      // Backpressure on beat0 of a 4b word.
      in_valid = 1'b1; in_word = 32'h89ABCDEF; prec = 2'b01; sgn = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp%0d_vals", c), out_vals, 64'hFFF8_FFF9_FFFA_FFFB);
         chk($sformatf("bp%0d_last", c), {63'd0, out_last}, 64'd0);
         chk($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_rel_b0", out_vals, 64'hFFF8_FFF9_FFFA_FFFB);
      tick();
      chk("bp_rel_b1", out_vals, 64'hFFFC_FFFD_FFFE_FFFF);
      chk("bp_rel_b1_last", {63'd0, out_last}, 64'd1);
      tick();
      chk("bp_idle", {63'd0, out_valid}, 64'd0);

      // Back-to-back 8b words with no bubble.
      in_valid = 1'b1; in_word = 32'h01020304; prec = 2'b00; sgn = 1'b0;
      tick();
      chk("tp_w0_vals", out_vals, 64'h0001_0002_0003_0004);
      chk("tp_w0_in_ready", {63'd0, in_ready}, 64'd1);
      in_word = 32'h05060708;
      tick();
      in_valid = 1'b0;
      chk("tp_w1_valid", {63'd0, out_valid}, 64'd1);
      chk("tp_w1_vals", out_vals, 64'h0005_0006_0007_0008);
      tick();
      chk("tp_idle", {63'd0, out_valid}, 64'd0);

      // Flush during beat1 of a 2b word with a competing input word.
      in_valid = 1'b1; in_word = 32'h1B1B1B1B; prec = 2'b10; sgn = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      flush = 1'b1; in_valid = 1'b1; in_word = 32'h80FF017F; prec = 2'b00;
      chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_vals", out_vals, 64'd0);
      tick();
      chk("flush_not_accepted", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset mid-word.
      in_valid = 1'b1; in_word = 32'h89ABCDEF; prec = 2'b01; sgn = 1'b1;
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_mid_vals", out_vals, 64'd0);
      rst = 1'b0;
      tick();
      chk("rst_mid_idle", {63'd0, out_valid}, 64'd0);

`ifdef NEUR_IN_ZP_EN
      in_valid = 1'b1; in_word = 32'h80FF017F; prec = 2'b00; sgn = 1'b0; zp = 8'd128;
      tick();
      in_valid = 1'b0;
      chk("zp_vals", out_vals, 64'h0000_007F_FF81_FFFF);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
